// File: rtl/m_tx_channel_arb_pkg.sv
// m_tx_channel_arb_pkg: shared widths, tx_type encodings, FSM states and saturating-increment helper
package m_tx_channel_arb_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int KEEP_W_DEF = 16;
  localparam int CID_W_DEF = 4;
  localparam int BN_W_DEF = 13;
  localparam int CNT_W = 16;
  localparam logic TX_TYPE_R = 1'b0;
  localparam logic TX_TYPE_B = 1'b1;
  typedef enum logic [1:0] {IDLE, LOCK_R, LOCK_B} state_e;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/m_tx_out_reg.sv
// m_tx_out_reg: single-entry valid/ready output register (clk, reset, load_i/data_i in, ready_i from sink, valid_o/data_o out, can_load_o = ~valid | ready)
module m_tx_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         can_load_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  assign can_load_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o = data_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (load_i) data_q <= data_i;
      valid_q <= load_i | (valid_q & ~ready_i);
    end
  end
endmodule

// File: rtl/m_tx_channel_arb.sv
// m_tx_channel_arb: packet-atomic round-robin merge of R/B response streams into one registered tx stream with per-type packet counters (clk, reset, r_channel_* / b_channel_* in, tx_* out, r_pkt_cnt/b_pkt_cnt status)
module m_tx_channel_arb
  import m_tx_channel_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEEP_W = KEEP_W_DEF,
  parameter int CID_W = CID_W_DEF,
  parameter int BN_W = BN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] r_channel,
  input  logic [KEEP_W-1:0] r_channel_keep,
  input  logic              r_channel_last,
  input  logic [CID_W-1:0]  r_channel_connection_id,
  input  logic [BN_W-1:0]   r_channel_byte_num,
  input  logic              r_channel_valid,
  output logic              r_channel_ready,
  input  logic [DATA_W-1:0] b_channel,
  input  logic [KEEP_W-1:0] b_channel_keep,
  input  logic              b_channel_last,
  input  logic [CID_W-1:0]  b_channel_connection_id,
  input  logic [BN_W-1:0]   b_channel_byte_num,
  input  logic              b_channel_valid,
  output logic              b_channel_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [KEEP_W-1:0] tx_keep,
  output logic              tx_last,
  output logic [CID_W-1:0]  tx_connection_id,
  output logic [BN_W-1:0]   tx_byte_num,
  output logic              tx_type,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [15:0]       r_pkt_cnt,
  output logic [15:0]       b_pkt_cnt
);
  localparam int PW = 1 + DATA_W + KEEP_W + 1 + CID_W + BN_W;
  state_e         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           gnt_r, gnt_b, can_load, r_hs, b_hs, tx_done;
  logic [PW-1:0]  beat, out;
  logic [CNT_W-1:0] r_cnt_q, b_cnt_q;
  // ptr_q holds the type granted last; a tie goes to the other one
  assign gnt_r = r_channel_valid & (~b_channel_valid | ptr_q == TX_TYPE_B);
  assign gnt_b = b_channel_valid & (~r_channel_valid | ptr_q == TX_TYPE_R);
  assign r_hs = r_channel_valid & r_channel_ready;
  assign b_hs = b_channel_valid & b_channel_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= TX_TYPE_B;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    state_d = r_hs ? (r_channel_last ? IDLE : LOCK_R) : b_hs ? (b_channel_last ? IDLE : LOCK_B) : state_q;
    ptr_d = (r_hs & r_channel_last) ? TX_TYPE_R : (b_hs & b_channel_last) ? TX_TYPE_B : ptr_q;
  end
  always_comb begin
    r_channel_ready = ~reset & can_load & (state_q == LOCK_R | (state_q == IDLE & gnt_r));
    b_channel_ready = ~reset & can_load & (state_q == LOCK_B | (state_q == IDLE & gnt_b));
  end
  assign beat = b_channel_ready
    ? {TX_TYPE_B, b_channel, b_channel_keep, b_channel_last, b_channel_connection_id, b_channel_byte_num}
    : {TX_TYPE_R, r_channel, r_channel_keep, r_channel_last, r_channel_connection_id, r_channel_byte_num};
  m_tx_out_reg #(.W(PW)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load_i    (r_hs | b_hs),
    .data_i    (beat),
    .ready_i   (tx_ready),
    .valid_o   (tx_valid),
    .data_o    (out),
    .can_load_o(can_load)
  );
  assign {tx_type, tx_data, tx_keep, tx_last, tx_connection_id, tx_byte_num} = out;
  assign tx_done = tx_valid & tx_ready & tx_last;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      r_cnt_q <= sat_inc(r_cnt_q, tx_done & tx_type == TX_TYPE_R);
      b_cnt_q <= sat_inc(b_cnt_q, tx_done & tx_type == TX_TYPE_B);
    end
  end
  assign r_pkt_cnt = r_cnt_q;
  assign b_pkt_cnt = b_cnt_q;
endmodule

// File: tb/tb_m_tx_channel_arb.sv
// tb_m_tx_channel_arb: directed self-checking bench for m_tx_channel_arb
module tb_m_tx_channel_arb;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] r_channel, b_channel, tx_data;
  logic [15:0]  r_channel_keep, b_channel_keep, tx_keep;
  logic         r_channel_last, b_channel_last, tx_last;
  logic [3:0]   r_channel_connection_id, b_channel_connection_id, tx_connection_id;
  logic [12:0]  r_channel_byte_num, b_channel_byte_num, tx_byte_num;
  logic         r_channel_valid, b_channel_valid, r_channel_ready, b_channel_ready;
  logic         tx_type, tx_valid, tx_ready;
  logic [15:0]  r_pkt_cnt, b_pkt_cnt;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  m_tx_channel_arb dut (
    .clk(clk), .reset(reset),
    .r_channel(r_channel), .r_channel_keep(r_channel_keep), .r_channel_last(r_channel_last),
    .r_channel_connection_id(r_channel_connection_id), .r_channel_byte_num(r_channel_byte_num),
    .r_channel_valid(r_channel_valid), .r_channel_ready(r_channel_ready),
    .b_channel(b_channel), .b_channel_keep(b_channel_keep), .b_channel_last(b_channel_last),
    .b_channel_connection_id(b_channel_connection_id), .b_channel_byte_num(b_channel_byte_num),
    .b_channel_valid(b_channel_valid), .b_channel_ready(b_channel_ready),
    .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last), .tx_connection_id(tx_connection_id),
    .tx_byte_num(tx_byte_num), .tx_type(tx_type), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .r_pkt_cnt(r_pkt_cnt), .b_pkt_cnt(b_pkt_cnt)
  );
  function automatic logic [127:0] pat(input int n);
    logic [31:0] v;
    v = n;
    return {v + 32'hC0DE_0000, v, ~v, v * 3 + 32'h5A5};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv_r(input logic v, input int n, input logic l);
    logic [127:0] p;
    p = pat(n);
    r_channel_valid = v;
    r_channel = p;
    r_channel_keep = p[15:0];
    r_channel_last = l;
    r_channel_connection_id = p[35:32];
    r_channel_byte_num = p[76:64];
  endtask
  task automatic drv_b(input logic v, input int n, input logic l);
    logic [127:0] p;
    p = pat(n);
    b_channel_valid = v;
    b_channel = p;
    b_channel_keep = p[15:0];
    b_channel_last = l;
    b_channel_connection_id = p[35:32];
    b_channel_byte_num = p[76:64];
  endtask
  task automatic exp_tx(input string tag, input int n, input logic l, input logic t);
    logic [127:0] p;
    p = pat(n);
    chk({tag, "_valid"}, tx_valid, 1'b1);
    chk({tag, "_data"}, tx_data, p);
    chk({tag, "_keep"}, tx_keep, p[15:0]);
    chk({tag, "_last"}, tx_last, l);
    chk({tag, "_cid"}, tx_connection_id, p[35:32]);
    chk({tag, "_bn"}, tx_byte_num, p[76:64]);
    chk({tag, "_type"}, tx_type, t);
  endtask
  task automatic chk_rdy(input string tag, input logic er, input logic eb);
    chk({tag, "_r_ready"}, r_channel_ready, er);
    chk({tag, "_b_ready"}, b_channel_ready, eb);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    tx_ready = 1'b1;
    drv_r(1'b1, 100, 1'b1);
    drv_b(1'b1, 200, 1'b1);
    tick();
    tick();
    chk_rdy("rst", 1'b0, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 128'h0);
    chk("rst_tx_type", tx_type, 1'b0);
    chk("rst_tx_last", tx_last, 1'b0);
    chk("rst_rcnt", r_pkt_cnt, 16'h0);
    chk("rst_bcnt", b_pkt_cnt, 16'h0);
    drv_r(1'b1, 1, 1'b0);
    drv_b(1'b1, 10, 1'b1);
    reset = 1'b0;
    #1;
    chk_rdy("tie_r_first", 1'b1, 1'b0);
    tick();
    exp_tx("m_r1", 1, 1'b0, 1'b0);
    drv_r(1'b1, 2, 1'b0);
    #1;
    chk_rdy("lock_r", 1'b1, 1'b0);
    tick();
    exp_tx("m_r2", 2, 1'b0, 1'b0);
    drv_r(1'b1, 3, 1'b1);
    tick();
    exp_tx("m_r3", 3, 1'b1, 1'b0);
    drv_r(1'b0, 0, 1'b0);
    #1;
    chk_rdy("m_switch", 1'b0, 1'b1);
    tick();
    exp_tx("m_b", 10, 1'b1, 1'b1);
    chk("m_rcnt", r_pkt_cnt, 16'd1);
    drv_b(1'b0, 0, 1'b0);
    tick();
    chk("m_drain_valid", tx_valid, 1'b0);
    chk("m_bcnt", b_pkt_cnt, 16'd1);
    drv_r(1'b1, 20, 1'b0);
    tick();
    exp_tx("s_r1", 20, 1'b0, 1'b0);
    drv_r(1'b1, 21, 1'b0);
    drv_b(1'b1, 30, 1'b1);
    #1;
    chk_rdy("s_stall1", 1'b1, 1'b0);
    tick();
    exp_tx("s_r2", 21, 1'b0, 1'b0);
    drv_r(1'b1, 22, 1'b0);
    #1;
    chk_rdy("s_stall2", 1'b1, 1'b0);
    tick();
    exp_tx("s_r3", 22, 1'b0, 1'b0);
    drv_r(1'b1, 23, 1'b1);
    #1;
    chk_rdy("s_stall3", 1'b1, 1'b0);
    tick();
    exp_tx("s_r4", 23, 1'b1, 1'b0);
    drv_r(1'b0, 0, 1'b0);
    #1;
    chk_rdy("s_release", 1'b0, 1'b1);
    tick();
    exp_tx("s_b", 30, 1'b1, 1'b1);
    drv_b(1'b0, 0, 1'b0);
    tick();
    chk("s_rcnt", r_pkt_cnt, 16'd2);
    chk("s_bcnt", b_pkt_cnt, 16'd2);
    drv_r(1'b1, 40, 1'b0);
    tick();
    exp_tx("bp_r1", 40, 1'b0, 1'b0);
    tx_ready = 1'b0;
    drv_r(1'b1, 41, 1'b0);
    drv_b(1'b1, 45, 1'b1);
    #1;
    chk_rdy("bp_start", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_tx("bp_hold", 40, 1'b0, 1'b0);
      chk_rdy("bp_hold", 1'b0, 1'b0);
    end
    tx_ready = 1'b1;
    #1;
    chk_rdy("bp_resume", 1'b1, 1'b0);
    tick();
    exp_tx("bp_r2", 41, 1'b0, 1'b0);
    drv_r(1'b0, 0, 1'b0);
    #1;
    chk("gap_b_ready", b_channel_ready, 1'b0);
    tick();
    chk("gap_tx_valid", tx_valid, 1'b0);
    chk("gap_b_ready2", b_channel_ready, 1'b0);
    drv_r(1'b1, 42, 1'b1);
    tick();
    exp_tx("bp_r3", 42, 1'b1, 1'b0);
    drv_r(1'b0, 0, 1'b0);
    #1;
    chk("bp_b_ready", b_channel_ready, 1'b1);
    tick();
    exp_tx("bp_b", 45, 1'b1, 1'b1);
    drv_b(1'b0, 0, 1'b0);
    tick();
    chk("bp_rcnt", r_pkt_cnt, 16'd3);
    chk("bp_bcnt", b_pkt_cnt, 16'd3);
    drv_r(1'b1, 50, 1'b1);
    drv_b(1'b1, 60, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_tx("alt", (i % 2) ? 60 : 50, 1'b1, i[0]);
    end
    drv_r(1'b0, 0, 1'b0);
    drv_b(1'b0, 0, 1'b0);
    tick();
    chk("alt_drain", tx_valid, 1'b0);
    chk("alt_rcnt", r_pkt_cnt, 16'd6);
    chk("alt_bcnt", b_pkt_cnt, 16'd6);
    drv_r(1'b1, 70, 1'b0);
    tick();
    exp_tx("rr_r1", 70, 1'b0, 1'b0);
    drv_r(1'b1, 71, 1'b0);
    tick();
    exp_tx("rr_r2", 71, 1'b0, 1'b0);
    reset = 1'b1;
    drv_r(1'b1, 72, 1'b0);
    drv_b(1'b1, 80, 1'b1);
    #1;
    chk_rdy("rr_in_reset", 1'b0, 1'b0);
    tick();
    chk("rr_tx_valid", tx_valid, 1'b0);
    chk("rr_tx_data", tx_data, 128'h0);
    chk("rr_rcnt", r_pkt_cnt, 16'd0);
    chk("rr_bcnt", b_pkt_cnt, 16'd0);
    reset = 1'b0;
    drv_r(1'b1, 73, 1'b1);
    #1;
    chk_rdy("rr_idle_tie", 1'b1, 1'b0);
    tick();
    exp_tx("rr_new_r", 73, 1'b1, 1'b0);
    drv_r(1'b0, 0, 1'b0);
    tick();
    exp_tx("rr_new_b", 80, 1'b1, 1'b1);
    drv_b(1'b0, 0, 1'b0);
    tick();
    chk("rr_after_rcnt", r_pkt_cnt, 16'd1);
    chk("rr_after_bcnt", b_pkt_cnt, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv_b(1'b1, 90, 1'b1);
    repeat (65535) tick();
    chk("sat_pre_bcnt", b_pkt_cnt, 16'hFFFE);
    repeat (5) tick();
    drv_b(1'b0, 0, 1'b0);
    tick();
    chk("sat_bcnt", b_pkt_cnt, 16'hFFFF);
    chk("sat_rcnt", r_pkt_cnt, 16'h0);
    chk("sat_drain", tx_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
